// File: rtl/bitty_pkg.sv
// Shared types and constants for the Bitty fetch unit: fetch state encoding,
// branch condition codes and the default end-of-program word.
package bitty_pkg;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_ISSUE,
    FS_WAIT,
    FS_NEXT,
    FS_HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_ZERO   = 2'b01,
    BR_NZERO  = 2'b10,
    BR_NEG    = 2'b11
  } br_cond_t;

  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;
  localparam logic [1:0]  BR_TAG        = 2'b10;

  function automatic logic br_taken(input logic [1:0] cond, input logic [15:0] reg_c);
    logic taken;
    case (br_cond_t'(cond))
      BR_ALWAYS: taken = 1'b1;
      BR_ZERO:   taken = (reg_c == 16'h0000);
      BR_NZERO:  taken = (reg_c != 16'h0000);
      BR_NEG:    taken = reg_c[15];
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/bitty_imem.sv
// Program store for the fetch unit: synchronous write from the host loader,
// asynchronous read at the program counter. Contents survive reset.
module bitty_imem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/issue sequencer for the BittyPro core. Define
// BITTY_FETCH_BRANCH_EN to execute tagged branch words locally instead of issuing them.
//
// state    | meaning
// IDLE     | after reset, waiting for start; imem loadable
// ISSUE    | word at pc presented and held for ISSUE_CYC cycles
// WAIT     | waiting for core_done, watchdog running
// NEXT     | one cycle to advance pc or stop at the last address
// HALT     | program ended (halt word, last address or timeout); imem loadable
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEF,
  parameter int          TIMEOUT   = 64,
  parameter int          ISSUE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              core_done,
  input  logic [15:0]       core_reg_c,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err
);

  localparam int HOLD_W = $clog2(ISSUE_CYC + 1);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ISSUE_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_LAST   = {ADDR_W{1'b1}};

`ifdef BITTY_FETCH_BRANCH_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif

  fetch_state_t      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WDOG_W-1:0] wdog;
  logic [15:0]       word;
  logic              idle_like;
  logic              is_branch;
  logic              br_go;
  logic [ADDR_W-1:0] br_target;

  assign idle_like = (state == FS_IDLE) || (state == FS_HALT);

  bitty_imem #(.ADDR_W(ADDR_W)) u_imem (
    .clk   (clk),
    .we    (load_en && idle_like),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (word)
  );

  assign is_branch = BRANCH_EN && (word[1:0] == BR_TAG);
  assign br_target = word[ADDR_W+3:4];
  assign br_go     = br_taken(word[3:2], core_reg_c);

  // Both timers are down-counters reloaded on state entry; zero is terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FS_IDLE;
      pc          <= '0;
      instruction <= 16'h0000;
      hold_cnt    <= '0;
      wdog        <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        FS_IDLE, FS_HALT: begin
          if (start) begin
            pc          <= '0;
            timeout_err <= 1'b0;
            hold_cnt    <= HOLD_LOAD;
            state       <= FS_ISSUE;
            busy        <= 1'b1;
            halted      <= 1'b0;
          end
        end
        FS_ISSUE: begin
          if (word == HALT_WORD) begin
            state  <= FS_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (is_branch) begin
            if (br_go) begin
              pc       <= br_target;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= FS_NEXT;
            end
          end else begin
            instruction <= word;
            if (hold_cnt == '0) begin
              wdog  <= WDOG_LOAD;
              state <= FS_WAIT;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end
        FS_WAIT: begin
          if (core_done) begin
            state <= FS_NEXT;
          end else if (wdog == '0) begin
            timeout_err <= 1'b1;
            state       <= FS_HALT;
            busy        <= 1'b0;
            halted      <= 1'b1;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        FS_NEXT: begin
          if (pc == PC_LAST) begin
            state  <= FS_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            pc       <= pc + 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= FS_ISSUE;
          end
        end
        default: begin
          state  <= FS_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: a timeline model of the program walk
// predicts every output cycle by cycle, plus directed literal checks.
module tb_bitty_fetch_unit;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 256;
  localparam int TIMEOUT   = 64;
  localparam int ISSUE_CYC = 2;
  localparam int MAXC      = 4096;

  logic        clk = 1'b0;
  logic        reset, start, load_en, core_done;
  logic [7:0]  load_addr;
  logic [15:0] load_data, core_reg_c;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic        busy, halted, timeout_err;

  always #5 clk = ~clk;

  bitty_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .core_done   (core_done),
    .core_reg_c  (core_reg_c),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

  logic [15:0] mem [DEPTH];
  logic [7:0]  e_pc  [MAXC];
  logic [15:0] e_ins [MAXC];
  bit          e_busy[MAXC], e_halt[MAXC], e_to[MAXC];
  bit          done_drv[MAXC], start_drv[MAXC];
  logic [7:0]  l_pc  [MAXC];
  logic [15:0] l_ins [MAXC];
  bit          l_halt[MAXC], l_to[MAXC];
  int          wait_start[DEPTH];

  int          n_vec, n_bad, cyc, e;
  bit          chk_en;
  logic [7:0]  m_pc, f_pc;
  logic [15:0] m_instr, f_instr;
  bit          m_halt, m_to, f_to;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      l_pc[cyc] = pc; l_ins[cyc] = instruction; l_halt[cyc] = halted; l_to[cyc] = timeout_err;
      if ({pc, instruction, busy, halted, timeout_err} !==
          {e_pc[cyc], e_ins[cyc], e_busy[cyc], e_halt[cyc], e_to[cyc]}) begin
        n_bad++;
        $display("FAIL cycle %0d: got pc=%0d instr=%h busy=%b halted=%b to=%b, want pc=%0d instr=%h busy=%b halted=%b to=%b",
                 cyc, pc, instruction, busy, halted, timeout_err,
                 e_pc[cyc], e_ins[cyc], e_busy[cyc], e_halt[cyc], e_to[cyc]);
      end
    end
  end

  task automatic put(input int c, input logic [7:0] p, input logic [15:0] ins,
                     input bit b, input bit h, input bit to);
    if (c < MAXC) begin
      e_pc[c] = p; e_ins[c] = ins; e_busy[c] = b; e_halt[c] = h; e_to[c] = to;
    end
  endtask

`ifdef BITTY_FETCH_BRANCH_EN
  function automatic bit br_ok(input logic [1:0] cond);
    case (cond)
      2'b00:   return 1'b1;
      2'b01:   return core_reg_c == 16'h0000;
      2'b10:   return core_reg_c != 16'h0000;
      default: return core_reg_c[15];
    endcase
  endfunction
`endif

  // Walks the program: an instruction occupies ISSUE_CYC issue cycles, d+1 wait
  // cycles and one advance cycle; a halt word ends the run one cycle after issue.
  task automatic build(input int dmode, input int stale);
    int t, w, d;
    logic [7:0]  p;
    logic [15:0] cur, word;
    bit fin, to;
    for (int i = 0; i < MAXC; i++) begin done_drv[i] = 0; start_drv[i] = 0; end
    put(0, m_pc, m_instr, 1'b0, m_halt, m_to);
    start_drv[0] = 1;
    p = '0; cur = m_instr; t = 1; fin = 0; to = 0;
    while (!fin) begin
      word = mem[p];
      put(t, p, cur, 1, 0, 0);
      if (t > MAXC - 100) begin
        n_vec++; n_bad++;
        $display("FAIL model_overrun: got cycle %0d want below %0d", t, MAXC - 100);
        e = t; fin = 1;
      end else if (word == 16'hFFFF) begin
        e = t + 1; fin = 1;
`ifdef BITTY_FETCH_BRANCH_EN
      end else if (word[1:0] == 2'b10 && br_ok(word[3:2])) begin
        p = word[11:4]; t = t + 1;
      end else if (word[1:0] == 2'b10) begin
        put(t + 1, p, cur, 1, 0, 0);
        if (p == 8'hFF) begin e = t + 2; fin = 1; end
        else begin p = p + 1; t = t + 2; end
`endif
      end else begin
        for (int k = 0; k < ISSUE_CYC; k++)
          done_drv[t+k] = (stale == 1) ? 1'b1 : (stale == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
        cur = word;
        for (int k = 1; k < ISSUE_CYC; k++) put(t + k, p, cur, 1, 0, 0);
        w = t + ISSUE_CYC;
        wait_start[p] = w;
        d = (dmode >= 0) ? dmode : int'($urandom_range(0, 4));
        if (dmode < 0 && $urandom_range(0, 40) == 0) d = TIMEOUT - 1;
        if (d >= TIMEOUT) begin
          for (int k = 0; k < TIMEOUT; k++) put(w + k, p, cur, 1, 0, 0);
          e = w + TIMEOUT; to = 1; fin = 1;
        end else begin
          for (int k = 0; k <= d; k++) put(w + k, p, cur, 1, 0, 0);
          done_drv[w+d] = 1;
          put(w + d + 1, p, cur, 1, 0, 0);
          if (p == 8'hFF) begin e = w + d + 2; fin = 1; end
          else begin p = p + 1; t = w + d + 2; end
        end
      end
    end
    for (int c = e; c <= e + 2; c++) put(c, p, cur, 0, 1, to);
    f_pc = p; f_instr = cur; f_to = to;
  endtask

  task automatic run_prog(input int dmode, input int stale, input int abort_at);
    build(dmode, stale);
    for (int c = 0; c <= e + 2; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        chk_en = 0; reset = 1;
        return;
      end
      cyc = c; start = start_drv[c]; core_done = done_drv[c]; load_en = 0;
      if (e_busy[c]) begin
        if ($urandom_range(0, 7) == 0) start = 1;
        if ($urandom_range(0, 3) == 0) begin
          load_en = 1; load_addr = 8'($urandom); load_data = 16'($urandom);
        end
      end
      chk_en = 1;
    end
    @(posedge clk); #1;
    chk_en = 0; start = 0; core_done = 0; load_en = 0;
    m_pc = f_pc; m_instr = f_instr; m_halt = 1; m_to = f_to;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    load_en = 1; load_addr = a; load_data = d; mem[a] = d;
    @(posedge clk); #1;
    load_en = 0;
  endtask

  initial begin
    logic [15:0] rw;
    int len;
    reset = 1; start = 0; load_en = 0; load_addr = '0; load_data = '0;
    core_done = 0; core_reg_c = '0; chk_en = 0; n_vec = 0; n_bad = 0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout_err, 0);
    reset = 0;
    m_pc = '0; m_instr = '0; m_halt = 0; m_to = 0;
    for (int i = 0; i < DEPTH; i++) load(8'(i), 16'hFFFF);

    load(8'd0, 16'h1234); load(8'd1, 16'h5678); load(8'd2, 16'hFFFF);
    run_prog(3, 0, -1);
    check("t1_model_len", e, 16);
    check("t1_first_instr", l_ins[2], 16'h1234);
    check("t1_second_instr", l_ins[9], 16'h5678);
    check("t1_not_yet_halted", l_halt[15], 0);
    check("t1_halted", l_halt[16], 1);
    check("t1_pc", pc, 2);
    check("t1_timeout", timeout_err, 0);

    run_prog(2, 1, -1);
    check("t2_pc_after_stale", l_pc[3], 0);
    check("t2_pc_in_next", l_pc[6], 0);
    check("t2_pc_advanced", l_pc[7], 1);

    run_prog(1000, 0, -1);
    check("t3_not_yet_timeout", l_halt[66], 0);
    check("t3_halt_on_timeout", l_halt[67], 1);
    check("t3_timeout_set", l_to[67], 1);
    run_prog(0, 0, -1);
    check("t3_timeout_held", l_to[0], 1);
    check("t3_start_clears", l_to[1], 0);

    run_prog(TIMEOUT - 1, 0, -1);
    check("done_wins_len", e, 136);
    check("done_wins_timeout", timeout_err, 0);

    load(8'd0, 16'h0032); load(8'd1, 16'h2222); load(8'd2, 16'h3333);
    load(8'd3, 16'h1111); load(8'd4, 16'hFFFF);
    run_prog(-1, 0, -1);
`ifdef BITTY_FETCH_BRANCH_EN
    check("t6_always_jump", l_pc[2], 3);
`else
    check("t6_branch_issued", l_ins[2], 16'h0032);
`endif
    load(8'd0, 16'h0036); load(8'd3, 16'h4444);
    core_reg_c = 16'h0000;
    run_prog(-1, 0, -1);
`ifdef BITTY_FETCH_BRANCH_EN
    check("t6_zero_jump", l_pc[2], 3);
`endif
    core_reg_c = 16'h8000;
    run_prog(-1, 2, -1);
`ifdef BITTY_FETCH_BRANCH_EN
    check("t6_zero_not_taken", l_pc[3], 1);
`else
    check("t6_branch_issued_b", l_ins[2], 16'h0036);
`endif

    for (int i = 0; i < 10; i++) load(8'(i), 16'((i << 4) | 1));
    load(8'd10, 16'hFFFF);
    run_prog(10, 0, 76);
    check("t5_model_wait5", wait_start[5], 73);
    #1;
    check("t5_reset_pc", pc, 0);
    check("t5_reset_instr", instruction, 0);
    check("t5_reset_busy", busy, 0);
    check("t5_reset_halted", halted, 0);
    reset = 0; start = 0; core_done = 0; load_en = 0;
    m_pc = '0; m_instr = '0; m_halt = 0; m_to = 0;
    run_prog(-1, 2, -1);
    check("t5_rerun_pc", pc, 10);
    check("t5_rerun_instr", instruction, 16'h0091);

    for (int i = 0; i < DEPTH; i++) load(8'(i), 16'h0001);
    run_prog(-1, 2, -1);
    check("t4_pc_last", pc, 255);
    check("t4_halted", halted, 1);

    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) begin
        rw = 16'($urandom);
        if (rw[1:0] == 2'b10) rw[1:0] = 2'b11;
        if (rw == 16'hFFFF) rw = 16'h7FFF;
        load(8'(i), rw);
      end
      load(8'(len), 16'hFFFF);
      core_reg_c = 16'($urandom);
      run_prog(-1, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
